// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment
// display that shares one segment bus. A packed BCD value arrives on a
// valid/ready write port and waits in a shadow register. It is copied into the
// displayed register only at a frame boundary, so a frame never mixes old and
// new digits.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   wr_valid   write request
//   wr_ready   controller can accept a write (no value pending)
//   wr_data    packed BCD, nibble k -> digit k
//   lzb_en     leading-zero blanking enable (combinational effect)
//   an         digit enables, active-low, exactly one bit low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   frame_tick one-cycle pulse in the last cycle of each frame
module seg_scan_ctrl #(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic              lzb_en,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic              pend_vld_reg, pend_vld_next;
    logic [4*NDIG-1:0] pend_reg, pend_next;
    logic [4*NDIG-1:0] disp_reg, disp_next;

    logic slot_end;
    logic frame_end;
    logic wr_fire;

    assign slot_end   = (cnt_reg == CNT_MAX);
    assign frame_end  = slot_end && (idx_reg == LAST_IDX);
    assign wr_ready   = !pend_vld_reg;
    assign wr_fire    = wr_valid && wr_ready;
    assign frame_tick = frame_end;

    // Next-state logic. A write and a frame-boundary copy can never collide:
    // the copy needs pend_vld=1, a transfer needs pend_vld=0. A write taken in
    // the boundary cycle therefore waits for the following boundary.
    always_comb begin
        cnt_next      = cnt_reg + CW'(1);
        idx_next      = idx_reg;
        pend_vld_next = pend_vld_reg;
        pend_next     = pend_reg;
        disp_next     = disp_reg;

        if (slot_end) begin
            cnt_next = '0;
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IW'(1);
        end

        if (frame_end && pend_vld_reg) begin
            disp_next     = pend_reg;
            pend_vld_next = 1'b0;
        end

        if (wr_fire) begin
            pend_next     = wr_data;
            pend_vld_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            idx_reg      <= '0;
            pend_vld_reg <= 1'b0;
            pend_reg     <= '0;
            disp_reg     <= '1;   // all nibbles 4'hF: display starts blank
        end else begin
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            pend_vld_reg <= pend_vld_next;
            pend_reg     <= pend_next;
            disp_reg     <= disp_next;
        end
    end

    // Per-digit views of the displayed value. zero_from[k] is set when
    // nibbles k..NDIG-1 are all zero, i.e. digit k is a leading zero.
    logic [3:0]  nib [NDIG];
    logic [NDIG:0] zero_from;

    assign zero_from[NDIG] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign nib[gi]       = disp_reg[4*gi +: 4];
            assign zero_from[gi] = zero_from[gi+1] && (disp_reg[4*gi +: 4] == 4'd0);
            assign an[gi]        = (idx_reg != IW'(gi));
        end
    endgenerate

    logic [3:0] cur_nib;
    logic       lz_blank;

    assign cur_nib  = nib[idx_reg];
    // Digit 0 always shows, so a value of zero still reads "0".
    assign lz_blank = lzb_en && (idx_reg != '0) && zero_from[idx_reg];

    always_comb begin
        seg = 7'b1111111;
        if (!lz_blank) begin
            case (cur_nib)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;  // non-BCD nibbles are blank
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (NDIG=4, DIV=4). A time-based model computes the
// expected outputs from the elapsed cycle count since reset; a per-cycle
// compare process checks it, and directed scenarios add literal expectations.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [4*NDIG-1:0] wr_data;
    logic              lzb_en;
    logic [NDIG-1:0]   an;
    logic [6:0]        seg;
    logic              frame_tick;

    int tests = 0;
    int fails = 0;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .lzb_en     (lzb_en),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_t;          // cycles since reset release
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pend_vld;
    bit          chk_en = 0;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t        <= 0;
            m_disp     <= 16'hFFFF;
            m_pend     <= 16'h0000;
            m_pend_vld <= 1'b0;
        end else begin
            if ((m_t % FRAME) == FRAME - 1 && m_pend_vld) begin
                m_disp     <= m_pend;
                m_pend_vld <= 1'b0;
            end
            if (wr_valid && !m_pend_vld) begin
                m_pend     <= wr_data;
                m_pend_vld <= 1'b1;
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int digit;
            int v;
            logic [6:0] exp_seg;
            logic [3:0] exp_an;
            digit  = (m_t / DIV) % NDIG;
            v      = int'((m_disp >> (4 * digit)) & 16'hF);
            exp_an = ~(4'b0001 << digit);
            if (lzb_en && digit > 0 && (m_disp >> (4 * digit)) == 16'h0)
                exp_seg = 7'b1111111;
            else
                exp_seg = seg_of(v);
            check("model_an", {12'h0, an}, {12'h0, exp_an});
            check("model_seg", {9'h0, seg}, {9'h0, exp_seg});
            check("model_frame_tick", {15'h0, frame_tick},
                  {15'h0, ((m_t % FRAME) == FRAME - 1)});
            check("model_wr_ready", {15'h0, wr_ready}, {15'h0, !m_pend_vld});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_tick();
        int n;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) break;
        end
        if (n == 64) check("wait_tick_timeout", 16'h0, 16'h1);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] d);
        int n;
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = d;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) break;
        end
        if (n == 64) check("write_timeout", 16'h0, 16'h1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        $display("[TB] write %h accepted at %0t", d, $time);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        lzb_en   = 1'b0;

        // 1. reset
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_an", {12'h0, an}, 16'h000E);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_wr_ready", {15'h0, wr_ready}, 16'h1);
        check("rst_frame_tick", {15'h0, frame_tick}, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_tick();
        skip(5);
        check("rotate_an1", {12'h0, an}, 16'h000D);
        skip(11);
        check("tick_period", {15'h0, frame_tick}, 16'h1);

        // 2. write 1234 mid-frame
        skip(5);
        do_write(16'h1234);
        @(negedge clk);
        check("w1234_ready_low", {15'h0, wr_ready}, 16'h0);
        check("w1234_still_blank", {9'h0, seg}, 16'h007F);
        wait_tick();
        @(negedge clk);
        check("w1234_ready_back", {15'h0, wr_ready}, 16'h1);
        check("w1234_d0", {9'h0, seg}, 16'h0019);
        skip(4);
        check("w1234_d1", {9'h0, seg}, 16'h0030);
        skip(4);
        check("w1234_d2", {9'h0, seg}, 16'h0024);
        skip(4);
        check("w1234_d3", {9'h0, seg}, 16'h0079);

        // 3. back-pressure
        do_write(16'h1111);
        do_write(16'h2222);
        @(negedge clk);
        check("bp_showing_1", {9'h0, seg}, 16'h0079);
        check("bp_ready_low", {15'h0, wr_ready}, 16'h0);
        wait_tick();
        @(negedge clk);
        check("bp_showing_2", {9'h0, seg}, 16'h0024);

        // 4. write in the boundary cycle
        wait_tick();
        wr_valid = 1'b1;
        wr_data  = 16'h9876;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        $display("[TB] write 9876 in boundary cycle at %0t", $time);
        @(negedge clk);
        check("bnd_not_bypassed", {9'h0, seg}, 16'h0024);
        check("bnd_accepted", {15'h0, wr_ready}, 16'h0);
        wait_tick();
        @(negedge clk);
        check("bnd_applied", {9'h0, seg}, 16'h0002);

        // 5. leading-zero blanking
        lzb_en = 1'b1;
        do_write(16'h0050);
        wait_tick();
        @(negedge clk);
        check("lzb_d0", {9'h0, seg}, 16'h0040);
        skip(4);
        check("lzb_d1", {9'h0, seg}, 16'h0012);
        skip(4);
        check("lzb_d2", {9'h0, seg}, 16'h007F);
        skip(4);
        check("lzb_d3", {9'h0, seg}, 16'h007F);
        @(posedge clk); #1;
        lzb_en = 1'b0;
        wait_tick();
        skip(9);
        check("nolzb_d2", {9'h0, seg}, 16'h0040);
        lzb_en = 1'b1;
        do_write(16'h0000);
        wait_tick();
        @(negedge clk);
        check("lzb0_d0", {9'h0, seg}, 16'h0040);
        skip(4);
        check("lzb0_d1", {9'h0, seg}, 16'h007F);
        @(posedge clk); #1;
        lzb_en = 1'b0;
        do_write(16'h00A3);
        wait_tick();
        @(negedge clk);
        check("a3_d0", {9'h0, seg}, 16'h0030);
        skip(4);
        check("a3_d1_blank", {9'h0, seg}, 16'h007F);

        // 6. reset mid-operation with a pending value
        wait_tick();
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        skip(9);
        check("mid_pending", {15'h0, wr_ready}, 16'h0);
        check("mid_at_d2", {12'h0, an}, 16'h000B);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_an", {12'h0, an}, 16'h000E);
        check("mid_rst_seg", {9'h0, seg}, 16'h007F);
        check("mid_rst_ready", {15'h0, wr_ready}, 16'h1);
        wait_tick();
        @(negedge clk);
        check("mid_pend_dropped", {9'h0, seg}, 16'h007F);

        skip(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
